// File: rtl/bus_memory.sv
// ============================================================================
// Module      : bus_memory
// Description : 32 x 8 synchronous RAM with address (MAR) and data (MBR)
//               registers on a shared tri-state data bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_memory #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              read,
  input  logic              write,
  input  logic              Ain,
  input  logic              Din,
  input  logic              Dout,
  input  logic [ADDR_W-1:0] Abus,
  inout  wire  [DATA_W-1:0] Dbus
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mbr;

  logic w_read_load;
  logic w_bus_load;

  // A simultaneous write wins over read; Din never captures our own driven value.
  assign w_read_load = read & ~write;
  assign w_bus_load  = Din & ~Dout & ~w_read_load;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mar <= '0;
      r_mbr <= '0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (Ain) begin
        r_mar <= Abus;
      end
      if (write) begin
        r_mem[r_mar] <= r_mbr;
      end
      if (w_read_load) begin
        r_mbr <= r_mem[r_mar];
      end else if (w_bus_load) begin
        r_mbr <= Dbus;
      end
    end
  end

  assign Dbus = Dout ? r_mbr : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_bus_memory.sv
// ============================================================================
// Module      : tb_bus_memory
// Description : Self-checking bench for bus_memory (table vectors + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_memory;

  logic       CLK;
  logic       RST;
  logic       read;
  logic       write;
  logic       Ain;
  logic       Din;
  logic       Dout;
  logic [4:0] Abus;
  wire  [7:0] Dbus;

  logic [7:0] r_tb_data;
  logic       r_tb_en;

  int n_checks;
  int n_pass;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[6];

  assign Dbus = r_tb_en ? r_tb_data : 8'bzzzzzzzz;

  bus_memory #(.ADDR_W(5), .DATA_W(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .read (read),
    .write(write),
    .Ain  (Ain),
    .Din  (Din),
    .Dout (Dout),
    .Abus (Abus),
    .Dbus (Dbus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply current strobes across one rising edge, then return everything idle.
  task automatic tick();
    @(posedge CLK);
    #1;
    RST = 0; read = 0; write = 0; Ain = 0; Din = 0; Dout = 0;
    r_tb_en = 0;
  endtask

  task automatic load(input logic ain, input logic [4:0] a, input logic din, input logic [7:0] d);
    Ain = ain; Abus = a;
    Din = din; r_tb_data = d; r_tb_en = din;
    tick();
  endtask

  task automatic write_word(input logic [4:0] a, input logic [7:0] d);
    load(1'b1, a, 1'b1, d);
    write = 1;
    tick();
  endtask

  // Sample the MBR on the bus and compare against the oldest scoreboard entry.
  task automatic sample_mbr(input string name);
    logic [7:0] e;
    Dout = 1;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %h expected scoreboard entry (queue empty)", name, Dbus);
    end else begin
      e = exp_q.pop_front();
      check(name, Dbus, e);
    end
    Dout = 0;
    #1;
  endtask

  task automatic read_word(input logic [4:0] a, input logic [7:0] exp, input string name);
    load(1'b1, a, 1'b0, 8'h00);
    read = 1;
    exp_q.push_back(exp);
    tick();
    sample_mbr(name);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    RST = 0; read = 0; write = 0; Ain = 0; Din = 0; Dout = 0;
    Abus = '0; r_tb_data = '0; r_tb_en = 0;

    tbl[0] = '{5'd7,  8'h00};
    tbl[1] = '{5'd8,  8'h01};
    tbl[2] = '{5'd9,  8'h80};
    tbl[3] = '{5'd10, 8'h7F};
    tbl[4] = '{5'd30, 8'hAA};
    tbl[5] = '{5'd31, 8'h55};

    repeat (2) @(posedge CLK);
    #1;

    // Reset clears MBR and every word
    RST = 1; read = 1; Din = 1; r_tb_data = 8'hEE; r_tb_en = 1;
    tick();
    exp_q.push_back(8'h00);
    sample_mbr("reset_mbr");
    for (int a = 0; a < 32; a++) read_word(5'(a), 8'h00, "reset_mem");

    // Tri-state when nobody drives
    Dout = 0; r_tb_en = 0;
    #1;
    n_checks++;
    if (Dbus === 8'bzzzzzzzz) n_pass++;
    else $display("FAIL tristate: got %b expected zzzzzzzz", Dbus);

    // Basic write/read
    write_word(5'd1, 8'hFF);
    read_word(5'd1, 8'hFF, "basic_rw");

    // Registered address: write uses old MAR while Ain loads the new one
    write_word(5'd3, 8'h77);
    load(1'b1, 5'd2, 1'b1, 8'hA5);
    write = 1; Ain = 1; Abus = 5'd3;
    tick();
    read = 1;                       // no Ain: proves MAR is now 3
    exp_q.push_back(8'h77);
    tick();
    sample_mbr("mar_updated_mem3_kept");
    read_word(5'd2, 8'hA5, "write_old_mar");

    // read beats Din
    write_word(5'd4, 8'h5A);
    load(1'b1, 5'd4, 1'b0, 8'h00);
    read = 1; Din = 1; r_tb_data = 8'h11; r_tb_en = 1;
    exp_q.push_back(8'h5A);
    tick();
    sample_mbr("read_over_din");

    // read+write: write happens, MBR holds
    write_word(5'd5, 8'h99);
    load(1'b1, 5'd5, 1'b1, 8'h3E);
    read = 1; write = 1;
    exp_q.push_back(8'h3E);
    tick();
    sample_mbr("rw_mbr_held");
    // Din ignored while the block is driving the bus
    Din = 1; Dout = 1;
    exp_q.push_back(8'h3E);
    tick();
    sample_mbr("din_ignored_dout");
    read_word(5'd5, 8'h3E, "rw_write_done");

    // Table vectors
    for (int i = 0; i < 6; i++) write_word(tbl[i].addr, tbl[i].data);
    for (int i = 0; i < 6; i++) read_word(tbl[i].addr, tbl[i].data, "table");

    // Full sweep
    for (int a = 0; a < 32; a++) write_word(5'(a), 8'(a) ^ 8'h3C);
    for (int a = 0; a < 32; a++) read_word(5'(a), 8'(a) ^ 8'h3C, "sweep");

    // Reset on the same edge as a write
    load(1'b1, 5'd6, 1'b1, 8'hC3);
    RST = 1; write = 1;
    tick();
    read_word(5'd6, 8'h00, "reset_over_write");
    read_word(5'd20, 8'h00, "reset_clears_other");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
